// File: rtl/counter_pkg.sv
// Shared display constants: active-low segment patterns, digit enables, digit select type.
package counter_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } digit_sel_t;

endpackage

// File: rtl/counter_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes blank the digit.
// Purely combinational, zero latency; no flow control.
module seg7_decode
  import counter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit < 4'd10) seg = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/counter_display.sv
// Two-digit multiplexed 7-seg driver for a 0..31 value, snapshotted once per frame.
// Outputs are registered one cycle behind prescaler state; no backpressure, display free-runs.
module counter_display
  import counter_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] q_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  digit_sel_t    sel;
  logic [4:0]    snap;
  logic          tick;
  logic [1:0]    tens;
  logic [3:0]    ones;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;

  assign tick = (cnt == CW'(REFRESH_DIV - 1));

  // Range compare and subtract is enough for 0..31; no divider needed
  always_comb begin
    tens = 2'd0;
    ones = snap[3:0];
    if (snap >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(snap - 5'd30);
    end else if (snap >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(snap - 5'd20);
    end else if (snap >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(snap - 5'd10);
    end
  end

  assign digit = (sel == DIG_TENS) ? {2'b00, tens} : ones;

  seg7_decode u_dec (
    .digit (digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      sel        <= DIG_ONES;
      snap       <= '0;
      seg        <= SEG_BLANK;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CW'(1);
      frame_tick <= tick && (sel == DIG_TENS);
      if (tick) begin
        sel <= (sel == DIG_ONES) ? DIG_TENS : DIG_ONES;
        // End of the tens period closes a frame: take the next value here only
        if (sel == DIG_TENS) snap <= q_in;
      end

      if (cnt == '0) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
      end else if (sel == DIG_ONES) begin
        an  <= AN_ONES;
        seg <= dec_seg;
      end else begin
        an  <= AN_TENS;
        seg <= (BLANK_LZ && tens == 2'd0) ? SEG_BLANK : dec_seg;
      end
    end
  end

endmodule

// File: tb/tb_counter_display.sv
// Bench for counter_display: two instances (leading-zero blanking on/off) against an arithmetic frame model.
module tb_counter_display;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] q_in = 5'd0;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       ft_a, ft_b;

  counter_display #(.REFRESH_DIV(D), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .reset(reset), .q_in(q_in), .seg(seg_a), .an(an_a), .frame_tick(ft_a));
  counter_display #(.REFRESH_DIV(D), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .reset(reset), .q_in(q_in), .seg(seg_b), .an(an_b), .frame_tick(ft_b));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] enc_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model: k = edges since reset release; t = k-1 is the state time an output reflects.
  // Period t/D alternates ones/tens; first cycle of each period blank; value changes every 2*D edges.
  int         k = 0;
  int         disp = 0;
  logic [6:0] e_seg_a = 7'h7F, e_seg_b = 7'h7F;
  logic [1:0] e_an = 2'b11;
  logic       e_ft = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= 0; disp <= 0; e_seg_a <= 7'h7F; e_seg_b <= 7'h7F; e_an <= 2'b11; e_ft <= 1'b0;
    end else begin
      k    <= k + 1;
      e_ft <= ((k + 1) % (2 * D)) == 0;
      if (k % D == 0) begin
        e_an <= 2'b11; e_seg_a <= 7'h7F; e_seg_b <= 7'h7F;
      end else if ((k / D) % 2 == 0) begin
        e_an <= 2'b10; e_seg_a <= enc_tab[disp % 10]; e_seg_b <= enc_tab[disp % 10];
      end else begin
        e_an    <= 2'b01;
        e_seg_a <= (disp / 10 == 0) ? 7'h7F : enc_tab[disp / 10];
        e_seg_b <= enc_tab[disp / 10];
      end
      if ((k + 1) % (2 * D) == 0) disp <= int'(q_in);
    end
  end

  logic [19:0] obs_v, exp_v;
  assign obs_v = {seg_a, seg_b, an_a, an_b, ft_a, ft_b};
  assign exp_v = {e_seg_a, e_seg_b, e_an, e_an, e_ft, e_ft};

  task automatic do_reset(input logic [4:0] q0);
    @(negedge clk);
    reset = 1'b0;
    q_in  = q0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    int ft_cnt;
    ft_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({seg_a, an_a, ft_a, seg_b, an_b} !== {7'h7F, 2'b11, 1'b0, 7'h7F, 2'b11}) begin
      miscompares++;
      $display("FAIL reset_hold got seg=%h an=%b ft=%b exp seg=7f an=11 ft=0", seg_a, an_a, ft_a);
    end
    q_in  = 5'd23;
    reset = 1'b1;
    #1;
    vectors++;
    if ({seg_a, an_a} !== {7'h7F, 2'b11}) begin
      miscompares++;
      $display("FAIL reset_release got seg=%h an=%b exp seg=7f an=11", seg_a, an_a);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_reset k=%0d got %h exp %h", k, obs_v, exp_v);
      end
      if (ft_a) ft_cnt++;
      if (k == 10) begin
        vectors++;
        if ({an_a, seg_a} !== {2'b10, 7'h30}) begin
          miscompares++;
          $display("FAIL ones_23 got an=%b seg=%h exp an=10 seg=30", an_a, seg_a);
        end
      end
      if (k == 14) begin
        vectors++;
        if ({an_a, seg_a} !== {2'b01, 7'h24}) begin
          miscompares++;
          $display("FAIL tens_23 got an=%b seg=%h exp an=01 seg=24", an_a, seg_a);
        end
      end
    end
    vectors++;
    if (ft_cnt != 2) begin
      miscompares++;
      $display("FAIL frame_tick_rate got %0d pulses exp 2 in 16 clocks", ft_cnt);
    end
  endtask

  task automatic test_blank_lz;
    do_reset(5'd7);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_blank_lz k=%0d got %h exp %h", k, obs_v, exp_v);
      end
      if (k == 10) begin
        vectors++;
        if (seg_a !== 7'h78) begin
          miscompares++;
          $display("FAIL ones_7 got seg=%h exp 78", seg_a);
        end
      end
      if (k == 14) begin
        vectors++;
        if ({an_a, seg_a, seg_b} !== {2'b01, 7'h7F, 7'h40}) begin
          miscompares++;
          $display("FAIL tens_7 got an=%b seg_lz1=%h seg_lz0=%h exp an=01 7f 40", an_a, seg_a, seg_b);
        end
      end
    end
  endtask

  task automatic test_tear_free;
    do_reset(5'd19);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_tear k=%0d got %h exp %h", k, obs_v, exp_v);
      end
      if (k == 14) begin
        vectors++;
        if (seg_a !== 7'h79) begin
          miscompares++;
          $display("FAIL tear_tens got seg=%h exp 79", seg_a);
        end
      end
      if (k == 18) begin
        vectors++;
        if (seg_a !== 7'h40) begin
          miscompares++;
          $display("FAIL tear_next_ones got seg=%h exp 40", seg_a);
        end
      end
      if (k == 22) begin
        vectors++;
        if (seg_a !== 7'h24) begin
          miscompares++;
          $display("FAIL tear_next_tens got seg=%h exp 24", seg_a);
        end
      end
      if (k == 12) q_in = 5'd20;
    end
  endtask

  task automatic test_boundaries;
    do_reset(5'd31);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_bound k=%0d got %h exp %h", k, obs_v, exp_v);
      end
      if (k == 10 && seg_a !== 7'h79) begin
        miscompares++;
        $display("FAIL ones_31 got seg=%h exp 79", seg_a);
      end
      if (k == 14 && seg_a !== 7'h30) begin
        miscompares++;
        $display("FAIL tens_31_after_wrap got seg=%h exp 30", seg_a);
      end
      if (k == 18 && seg_a !== 7'h40) begin
        miscompares++;
        $display("FAIL ones_0 got seg=%h exp 40", seg_a);
      end
      if (k == 22 && {an_a, seg_a} !== {2'b01, 7'h7F}) begin
        miscompares++;
        $display("FAIL tens_0 got an=%b seg=%h exp an=01 seg=7f", an_a, seg_a);
      end
      if (k == 10 || k == 14 || k == 18 || k == 22) vectors++;
      if (k == 12) q_in = 5'd0;
    end
  endtask

  task automatic test_async_reset;
    do_reset(5'd25);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_async k=%0d got %h exp %h", k, obs_v, exp_v);
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({seg_a, an_a, ft_a, seg_b, an_b, ft_b} !== {7'h7F, 2'b11, 1'b0, 7'h7F, 2'b11, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got seg=%h an=%b ft=%b exp seg=7f an=11 ft=0", seg_a, an_a, ft_a);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_restart k=%0d got %h exp %h", k, obs_v, exp_v);
      end
      if (k == 2) begin
        vectors++;
        if ({an_a, seg_a} !== {2'b10, 7'h40}) begin
          miscompares++;
          $display("FAIL restart_ones got an=%b seg=%h exp an=10 seg=40", an_a, seg_a);
        end
      end
    end
  endtask

  task automatic test_blanking;
    int         blanks;
    logic [1:0] prev_an;
    do_reset(5'($urandom_range(0, 31)));
    blanks  = 0;
    prev_an = an_a;
    for (int i = 0; i < 10 * 2 * D; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_blanking k=%0d got %h exp %h", k, obs_v, exp_v);
      end
      vectors++;
      if (an_a === 2'b00 || (prev_an === 2'b10 && an_a === 2'b01) || (prev_an === 2'b01 && an_a === 2'b10)) begin
        miscompares++;
        $display("FAIL an_sequence k=%0d got %b after %b", k, an_a, prev_an);
      end
      if (an_a === 2'b11) blanks++;
      if (k % D == 0) begin
        vectors++;
        if (blanks != 1) begin
          miscompares++;
          $display("FAIL blanks_per_period k=%0d got %0d exp 1", k, blanks);
        end
        blanks = 0;
      end
      prev_an = an_a;
      if ($urandom_range(0, 4) == 0) q_in = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic test_random;
    do_reset(5'($urandom_range(0, 31)));
    for (int i = 0; i < 40 * 2 * D; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_random k=%0d q=%0d got %h exp %h", k, q_in, obs_v, exp_v);
      end
      if ($urandom_range(0, 2) == 0) q_in = 5'($urandom_range(0, 31));
    end
  endtask

  initial begin
    test_reset;
    test_blank_lz;
    test_tear_free;
    test_boundaries;
    test_async_reset;
    test_blanking;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_display.md
Name: counter_display

Overview:
Downstream display stage for the 5-bit up/down counter. It takes the counter value q (0..31), converts it to two decimal digits and drives a time-multiplexed, two-digit, common-anode 7-segment display. A refresh prescaler alternates the digits. The value is snapshotted once per frame so a digit pair never tears, and a one-cycle blank between digits suppresses ghosting.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit period; legal minimum 2; prescaler width is clog2(REFRESH_DIV).
BLANK_LZ, 1, 1 = blank the tens digit when it is 0; 0 = show "0".

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
q_in  input  5  counter value to display, unsigned 0..31; all codes valid
seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}; registered
an  output  2  digit enable, active-low; an[0] = ones digit, an[1] = tens digit; registered
frame_tick  output  1  one-cycle pulse when a new snapshot is taken; registered

Behaviour:
- Clock and reset: one clock, clk. Reset (port reset) is asynchronous and active-low.
- Reset values: cnt=0, sel=0 (ones), snap=0, seg=7'h7F, an=2'b11, frame_tick=0. Asserting reset mid-period forces these values immediately, without waiting for a clock edge. After release, operation restarts at a fresh ones period.
- Prescaler cnt:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is asserted when cnt==REFRESH_DIV-1.
- Digit select: on the edge where tick is true, sel toggles (0 = ones, 1 = tens).
- Snapshot:
  - On a tick edge with sel==1 (tens to ones, i.e. start of a new frame), snap<=q_in and frame_tick<=1 for exactly one cycle.
  - q_in is sampled at no other time. Changes to q_in mid-frame are not visible until the next frame.
- BCD conversion (combinational from snap):
  - tens = 3 if snap>=30, 2 if >=20, 1 if >=10, else 0.
  - ones = snap - 10*tens, range 0..9.
  - No divider.
- Output registers: each edge samples the current cnt, sel and snap. Outputs therefore lag state by one cycle.
  - cnt==0: an<=2'b11, seg<=7'h7F (blank cycle; exactly one per digit period).
  - else sel==0: an<=2'b10, seg<=enc(ones).
  - else sel==1: an<=2'b01, seg<=enc(tens); if BLANK_LZ and tens==0, seg<=7'h7F while an stays 2'b01.
- Encoding enc(d), active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Undefined digits map to 7'h7F.
- Start-up: the first ones period after reset displays snap=0. The first real sample occurs at the end of the first tens period.
- Boundaries:
  - q_in=0 shows ones "0" with the tens digit blank or "0" per BLANK_LZ.
  - q_in=31 shows "31".
  - A counter wrap 31->0 or 0->31 mid-frame appears only at the next frame.

Decomposition:
- Shared package counter_pkg holds:
  - SEG_BLANK=7'h7F and the SEG_DIGIT[0:9] constant table;
  - AN_OFF=2'b11, AN_ONES=2'b10, AN_TENS=2'b01;
  - a digit_sel_t typedef {DIG_ONES, DIG_TENS}.
- One sub-module, seg7_decode: combinational 4-bit BCD to 7-bit active-low segments, using the package table. It is instantiated once on a muxed digit.

Test Plan:
1. REFRESH_DIV=4; hold reset low, then release with q_in=23. Immediately: seg=7F, an=11. After the first frame: ones period shows an=10/seg=30 ("3"), tens period shows an=01/seg=24 ("2"). frame_tick pulses once every 8 clocks.
2. q_in=7, BLANK_LZ=1 -> ones seg=78; tens an=01 with seg=7F. Same value with BLANK_LZ=0 -> tens seg=40.
3. Tear-free: q_in=19 captured; change to 20 during the tens period -> "1" is still shown. The next frame shows ones seg=40 ("0") and tens seg=24 ("2").
4. Boundaries: q_in=31 -> ones 79, tens 30. q_in=0 -> ones 40, tens blank. A 31->0 step mid-frame appears only after the next frame_tick.
5. Assert reset asynchronously between clock edges during a tens period -> seg=7F, an=11, frame_tick=0 in the same delta, with no clock. After release, the sequence restarts with a ones period showing 0.
6. Blanking check over 10 frames: exactly one an=11 cycle per digit period. an is never 2'b00, and an never switches directly between 10 and 01 without an 11 cycle.
